// File: rtl/axi_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter_if
//
// Purpose: single-beat AXI3 bus between the fetch/data arbiter (master) and
// the memory system (slave). Only the fields the arbiter drives or samples
// are present; response codes are not carried because nothing consumes them.
//
// Signal summary:
//   AR : arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
//        arvalid  (master -> slave), arready (slave -> master)
//   R  : rid, rdata, rlast, rvalid (slave -> master), rready (master -> slave)
//   AW : awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
//        awvalid  (master -> slave), awready (slave -> master)
//   W  : wid, wdata, wstrb, wlast, wvalid (master -> slave), wready
//   B  : bvalid (slave -> master), bready (master -> slave)
//
// Handshake rule for every channel: a transfer happens on a rising clock
// edge where valid and ready are both high. The source holds valid and its
// payload stable until that edge; ready may be raised or dropped freely.
// ---------------------------------------------------------------------------
interface axi_mem_arbiter_if;
  // AR channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // R channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AW channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // W channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // B channel
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter
//
// Purpose: shares one AXI master port between the instruction-fetch and the
// data-memory requesters. Each access is a single-beat read or write; only
// one transaction is ever outstanding. Returned data is held in registers
// and a per-requester done flag masks the stall until the whole pipeline
// advances, so a frozen requester that keeps its request high never issues
// the same access twice.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   inst_req        fetch request (level), inst_addr its address
//   inst_rdata      last fetched instruction word (registered)
//   fetch_stall     fetch still waiting (to hazard unit FetchStall)
//   data_req        data request (level); data_wr selects write
//   data_size       0 byte / 1 half / 2 word, driven on arsize/awsize
//   data_addr, data_wstrb, data_wdata   access address and write payload
//   data_rdata      last load data (registered)
//   memory_stall    data access still waiting (to hazard unit MemoryStall)
//   longest_stall   pipeline frozen (hazard unit LongestStall)
//   axi             AXI master port
//   dbg_state_o     current FSM state, for observation only
//
// Requester contract: a request is pending while req is high and that
// requester's done flag is clear. Address and payload are sampled only on
// the cycle the FSM leaves IDLE.
// ---------------------------------------------------------------------------
module axi_mem_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        fetch_stall,
  // data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        memory_stall,
  // hazard unit
  input  logic        longest_stall,
  // memory bus
  axi_mem_arbiter_if.master axi,
  // observation
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;        // 1 = data requester owns the bus
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_ok_q, aw_ok_d;        // AW handshake already done
  logic        w_ok_q, w_ok_d;          // W handshake already done
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic inst_pend, data_pend;
  logic inst_set, data_set;
  logic ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic aw_hs, w_hs;

  assign inst_pend = inst_req & ~inst_done_q;
  assign data_pend = data_req & ~data_done_q;

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      addr_q       <= 32'd0;
      size_q       <= 2'd0;
      wstrb_q      <= 4'd0;
      wdata_q      <= 32'd0;
      aw_ok_q      <= 1'b0;
      w_ok_q       <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      aw_ok_q      <= aw_ok_d;
      w_ok_q       <= w_ok_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // ------------------------------------------------------------------------
  // Next state and channel controls
  // ------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    aw_ok_d      = aw_ok_q;
    w_ok_d       = w_ok_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_set     = 1'b0;
    data_set     = 1'b0;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
    aw_valid     = 1'b0;
    w_valid      = 1'b0;
    b_ready      = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;

    unique case (state_q)
      IDLE: begin
        aw_ok_d = 1'b0;
        w_ok_d  = 1'b0;
        // Data wins a tie: a stalled memory stage holds up everything behind it.
        if (data_pend) begin
          owner_d = 1'b1;
          addr_d  = data_addr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          wdata_d = data_wdata;
          state_d = data_wr ? WR_ADDR : RD_ADDR;
        end else if (inst_pend) begin
          owner_d = 1'b0;
          addr_d  = inst_addr;
          size_d  = 2'd2;            // fetches are always full words
          state_d = RD_ADDR;
        end
      end

      RD_ADDR: begin
        ar_valid = 1'b1;
        if (axi.arready) state_d = RD_DATA;
      end

      RD_DATA: begin
        r_ready = 1'b1;
        // rid needs no check: nothing else can be in flight.
        if (axi.rvalid && axi.rlast) begin
          if (owner_q) begin
            data_rdata_d = axi.rdata;
            data_set     = 1'b1;
          end else begin
            inst_rdata_d = axi.rdata;
            inst_set     = 1'b1;
          end
          state_d = IDLE;
        end
      end

      WR_ADDR: begin
        // AW and W start together; each drops after its own handshake.
        aw_valid = ~aw_ok_q;
        w_valid  = ~w_ok_q;
        aw_hs    = aw_valid & axi.awready;
        w_hs     = w_valid & axi.wready;
        aw_ok_d  = aw_ok_q | aw_hs;
        w_ok_d   = w_ok_q | w_hs;
        if (aw_ok_d && w_ok_d) state_d = WR_RESP;
      end

      WR_RESP: begin
        b_ready = 1'b1;
        if (axi.bvalid) begin
          data_set = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A completion always sets its flag, even on a cycle that would clear it;
    // otherwise the stall would reassert before the pipeline consumed the data.
    inst_done_d = inst_set | (inst_done_q & longest_stall);
    data_done_d = data_set | (data_done_q & longest_stall);
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign fetch_stall  = inst_pend;
  assign memory_stall = data_pend;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign dbg_state_o  = state_q;

  assign axi.arid    = owner_q ? DATA_ID : INST_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = ar_valid;
  assign axi.rready  = r_ready;

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = aw_valid;

  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_valid;
  assign axi.bready  = b_ready;

  // rid is deliberately ignored.
  logic unused_rid;
  assign unused_rid = ^axi.rid;

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Shares one AXI master port between the instruction-fetch requester and the data-memory requester.
- Sequences single-beat AXI read and write transactions.
- Produces the FetchStall and MemoryStall inputs consumed by the hazard unit.
- Holds returned data until the whole pipeline stops stalling, so a frozen requester never re-issues a completed access.

Parameters:
- INST_ID, 4'd0, ARID used for instruction reads.
- DATA_ID, 4'd1, ARID/AWID used for data accesses.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- inst_req  in  1  instruction read request, level, held while fetch needs data
- inst_addr  in  32  instruction address
- inst_rdata  out  32  registered instruction word
- fetch_stall  out  1  to hazard FetchStall
- data_req  in  1  data access request, level
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  byte/half/word, driven onto arsize/awsize
- data_addr  in  32  data address
- data_wstrb  in  4  write byte strobes
- data_wdata  in  32  write data
- data_rdata  out  32  registered load data
- memory_stall  out  1  to hazard MemoryStall
- longest_stall  in  1  hazard LongestStall
- arid, araddr, arsize, arvalid  out  4/32/3/1  AR channel
- arready  in  1  AR channel
- rid, rdata, rlast, rvalid  in  4/32/1/1  R channel
- rready  out  1  R channel
- awid, awaddr, awsize, awvalid  out  4/32/3/1  AW channel
- awready  in  1  AW channel
- wdata, wstrb, wlast, wvalid  out  32/4/1/1  W channel
- wready  in  1  W channel
- bvalid  in  1  B channel
- bready  out  1  B channel

Behaviour:
- Constant AXI fields:
  - arlen = awlen = 0, arburst = awburst = 2'b01, wlast = 1.
  - All lock/cache/prot fields are 0.
  - wid = DATA_ID.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP. Reset (async): IDLE.
- Reset values: all valid/ready outputs 0; inst_rdata = data_rdata = 0; both done flags 0; owner = inst.
- Pending flags:
  - inst_pend = inst_req & ~inst_done.
  - data_pend = data_req & ~data_done.
- IDLE transitions:
  - If data_pend: owner = data; go to WR_ADDR when data_wr, otherwise RD_ADDR.
  - Else if inst_pend: owner = inst; go to RD_ADDR.
  - Data always wins a simultaneous request.
- Address, size, strobes and wdata are latched on leaving IDLE. Requester inputs are ignored thereafter until IDLE.
- RD_ADDR:
  - arvalid = 1; arid = owner's ID.
  - arsize: data_size for data; 3'd2 for inst.
  - On arvalid & arready go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid & rlast: latch rdata into the owner's rdata register, set the owner's done flag, go to IDLE.
  - rid is not checked, because only one transaction is ever outstanding.
- WR_ADDR:
  - awvalid and wvalid are asserted together, each dropping independently after its own handshake.
  - Internal aw_ok/w_ok flags track completion.
  - Go to WR_RESP when both have completed, including the same cycle.
- WR_RESP:
  - bready = 1.
  - On bvalid: set data_done, go to IDLE. bresp is ignored.
- Done flags:
  - Each clears on the first cycle with longest_stall = 0 and the pipeline advancing.
  - A flag set in the same cycle it would clear stays set if longest_stall = 1, and clears next non-stall cycle.
- Stall outputs (combinational):
  - fetch_stall = inst_req & ~inst_done.
  - memory_stall = data_req & ~data_done.
  - Both deassert the cycle after the final handshake.
- inst_rdata/data_rdata hold their value until the next completion for that requester.
- Only one AXI transaction is outstanding at any time; there is no AR/AW overlap.
- Reset mid-transaction: FSM returns to IDLE and the transaction is abandoned. The slave shares the same rst.

Test Plan:
- Instruction read:
  - Stimulus: inst_req = 1, inst_addr = 0xBFC00000; slave gives arready after 2 cycles, then rdata = 0x3C1D8000 with rvalid 1 cycle later.
  - Required: araddr = 0xBFC00000, arid = 0, arsize = 2; inst_rdata = 0x3C1D8000; fetch_stall high until the cycle after the R handshake.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (read, 0x80001000) rise together.
  - Required: AR for data (arid = 1) first; instruction AR issued only after data R completes; memory_stall falls before fetch_stall.
- Data write, handshake ordering:
  - Stimulus: data_wr = 1, addr 0x80002004, wstrb = 4'b0011, wdata = 0x0000BEEF; wready 3 cycles before awready.
  - Required: wvalid drops after its handshake while awvalid stays high; bready only after both; memory_stall drops the cycle after bvalid.
- Held stall:
  - Stimulus: instruction read completes while longest_stall = 1 (data still stalling) and inst_req stays high.
  - Required: no second AR for the instruction; inst_rdata held; fetch_stall = 0; done flag clears once longest_stall = 0.
- Back-to-back loads:
  - Stimulus: two loads to 0x80000010 and 0x80000014 on consecutive non-stall cycles.
  - Required: two separate AR handshakes, each data_rdata correct, no overlap.
- Reset in RD_DATA:
  - Stimulus: assert rst while waiting for rvalid.
  - Required: arvalid/rready/awvalid/wvalid/bready = 0 immediately (async); rdata registers = 0; FSM in IDLE after release.
